store_queue: RTL and testbench

Store-side counterpart to the load path: the load path pulls words from data memory and extracts and extends lb/lbu/lh/lhu/lw results before the register file. This block takes sb/sh/sw requests from the execute stage. It performs the following steps:
- checks alignment;
- generates the word-aligned address, lane-replicated write data and 4-bit byte enable;
- buffers the store in a small FIFO;
- drains it to data memory over the mem_write/mem_resp handshake.

It sits between the execute stage and the data-memory port. It exposes `empty` so the pipeline can hold loads or fences until all stores have drained.

---
 rtl/store_queue.sv | 144 ++++++++++++++
 tb/tb_store_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// rtl/store_queue.sv - sb/sh/sw alignment check, lane formation, store FIFO and memory drain FSM
// Stores are consumed in order; illegal or misaligned requests are dropped with a one-cycle flag.
module store_queue #(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_st_valid,
  output logic                         o_st_ready,
  input  logic [2:0]                   i_st_funct3,
  input  logic [31:0]                  i_st_addr,
  input  logic [31:0]                  i_st_data,
  output logic                         o_st_misaligned,
  output logic [31:0]                  o_mem_address,
  output logic [31:0]                  o_mem_wdata,
  output logic [3:0]                   o_mem_byte_enable,
  output logic                         o_mem_write,
  input  logic                         i_mem_resp,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic            r_misaligned;

  logic [29:0]     r_addr_q [DEPTH];
  logic [31:0]     r_data_q [DEPTH];
  logic [3:0]      r_be_q   [DEPTH];

  logic            w_accept;
  logic            w_bad;
  logic            w_enq;
  logic            w_pop;
  logic [1:0]      w_off;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;

  assign w_off    = i_st_addr[1:0];
  assign w_accept = i_st_valid && o_st_ready;
  assign w_enq    = w_accept && !w_bad;
  assign w_pop    = (r_state == S_WRITE) && i_mem_resp;

  // Lane replication lets the memory side ignore the byte offset; only the mask selects lanes.
  always_comb begin
    w_bad   = 1'b0;
    w_be    = 4'b0000;
    w_wdata = i_st_data;
    case (i_st_funct3)
      3'b000: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{i_st_data[7:0]}};
      end
      3'b001: begin
        w_bad   = w_off[0];
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{i_st_data[15:0]}};
      end
      3'b010: begin
        w_bad = |w_off;
        w_be  = 4'b1111;
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_addr_q[r_tail] <= i_st_addr[31:2];
      r_data_q[r_tail] <= w_wdata;
      r_be_q[r_tail]   <= w_be;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_accept && w_bad;
      if (w_enq) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_enq && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_enq) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every write returns through IDLE, guaranteeing a low cycle on mem_write between entries.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_WRITE;
      S_WRITE: if (i_mem_resp)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_write       = (r_state == S_WRITE);
    o_mem_address     = 32'h0;
    o_mem_wdata       = 32'h0;
    o_mem_byte_enable = 4'b0000;
    if (r_count != '0) begin
      o_mem_address     = {r_addr_q[r_head], 2'b00};
      o_mem_wdata       = r_data_q[r_head];
      o_mem_byte_enable = r_be_q[r_head];
    end
  end

  assign o_st_ready      = (r_count < L_DEPTH);
  assign o_st_misaligned = r_misaligned;
  assign o_empty         = (r_count == '0) && (r_state == S_IDLE);
  assign o_count         = r_count;

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - scoreboard bench for store_queue
module tb_store_queue;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  st_funct3 = 3'b000;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        st_misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_write;
  logic        mem_resp;
  logic        empty;
  logic [1:0]  count;

  logic auto_resp = 1'b0;
  logic man_resp  = 1'b0;
  logic resp_en   = 1'b0;
  logic rnd_delay = 1'b0;
  int   fixed_delay = 2;
  int   dly;

  wr_t  sb[$];
  wr_t  cur;
  logic cur_v = 1'b0;
  logic prev_mw = 1'b0;
  int   nwrites = 0;
  int   total = 0;
  int   bad = 0;

  assign mem_resp = auto_resp | man_resp;

  store_queue #(.DEPTH(2)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_st_valid        (st_valid),
    .o_st_ready        (st_ready),
    .i_st_funct3       (st_funct3),
    .i_st_addr         (st_addr),
    .i_st_data         (st_data),
    .o_st_misaligned   (st_misaligned),
    .o_mem_address     (mem_address),
    .o_mem_wdata       (mem_wdata),
    .o_mem_byte_enable (mem_byte_enable),
    .o_mem_write       (mem_write),
    .i_mem_resp        (mem_resp),
    .o_empty           (empty),
    .o_count           (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: each rising mem_write pops one expected write; the head must stay stable while held.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mw = 1'b0;
      cur_v   = 1'b0;
    end else begin
      if (mem_write) begin
        if (!prev_mw) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=%h required=none", mem_address);
            cur_v = 1'b0;
          end else begin
            cur   = sb.pop_front();
            cur_v = 1'b1;
            nwrites++;
            chk("wr_addr", mem_address, cur.a);
            chk("wr_be", {28'h0, mem_byte_enable}, {28'h0, cur.be});
            chk("wr_data", mem_wdata, cur.d);
          end
        end else if (cur_v) begin
          chk("hold_addr", mem_address, cur.a);
          chk("hold_data", mem_wdata, cur.d);
        end
      end
      prev_mw = mem_write;
    end
  end

  // Memory model: responds after a delay, then checks mem_write dropped after the popping edge.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && mem_write) begin
        dly = rnd_delay ? int'($urandom_range(0, 4)) : fixed_delay;
        repeat (dly) @(negedge clk);
        auto_resp = 1'b1;
        @(negedge clk);
        auto_resp = 1'b0;
        chk("gap_after_resp", {31'h0, mem_write}, 32'h0);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                       input logic exp_bad, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ed);
    int n;
    wr_t e;
    st_funct3 = f3;
    st_addr   = addr;
    st_data   = data;
    st_valid  = 1'b1;
    n = 0;
    while (!st_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!st_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=%h required=ready", addr);
      st_valid = 1'b0;
      return;
    end
    if (!exp_bad) begin
      e.a  = ea;
      e.be = ebe;
      e.d  = ed;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    chk("misaligned_pulse", {31'h0, st_misaligned}, {31'h0, exp_bad});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(empty && sb.size() == 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", {31'h0, empty}, 32'h1);
    chk("drain_sb", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_count", {30'h0, count}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", {28'h0, mem_byte_enable}, 32'h0);
    chk("rst_misaligned", {31'h0, st_misaligned}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency and reset mid-write
    issue(3'b010, 32'h0000_0040, 32'h1111_1111, 1'b0, 32'h0000_0040, 4'hF, 32'h1111_1111);
    chk("lat_count1", {30'h0, count}, 32'h1);
    chk("lat_write_low", {31'h0, mem_write}, 32'h0);
    @(posedge clk);
    #1;
    chk("lat_write_high", {31'h0, mem_write}, 32'h1);
    issue(3'b010, 32'h0000_0044, 32'h2222_2222, 1'b0, 32'h0000_0044, 4'hF, 32'h2222_2222);
    chk("pre_rst_count", {30'h0, count}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mid_count", {30'h0, count}, 32'h0);
    chk("rst_mid_empty", {31'h0, empty}, 32'h1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    man_resp = 1'b1;
    @(posedge clk);
    #1;
    man_resp = 1'b0;
    repeat (2) begin
      chk("stray_resp_count", {30'h0, count}, 32'h0);
      chk("stray_resp_write", {31'h0, mem_write}, 32'h0);
      @(posedge clk);
      #1;
    end

    // Ordering of sb/sh/sw with fixed memory latency
    resp_en = 1'b1;
    fixed_delay = 2;
    issue(3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
    issue(3'b001, 32'h0000_2002, 32'h0000_1234, 1'b0, 32'h0000_2000, 4'b1100, 32'h1234_1234);
    issue(3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF);
    wait_drain();
    chk("order_nwrites", nwrites, 4);

    // Misaligned and illegal requests
    chk("mis_ready_sh", {31'h0, st_ready}, 32'h1);
    issue(3'b001, 32'h0000_0011, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
    chk("mis_ready_sw", {31'h0, st_ready}, 32'h1);
    issue(3'b010, 32'h0000_0022, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
    chk("mis_ready_f3", {31'h0, st_ready}, 32'h1);
    issue(3'b011, 32'h0000_0000, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("mis_pulse_end", {31'h0, st_misaligned}, 32'h0);
    chk("mis_count", {30'h0, count}, 32'h0);
    chk("mis_no_write", {31'h0, mem_write}, 32'h0);
    chk("mis_empty", {31'h0, empty}, 32'h1);

    // Backpressure with DEPTH=2
    resp_en = 1'b0;
    issue(3'b010, 32'h0000_0500, 32'hAAAA_0001, 1'b0, 32'h0000_0500, 4'hF, 32'hAAAA_0001);
    issue(3'b010, 32'h0000_0504, 32'hAAAA_0002, 1'b0, 32'h0000_0504, 4'hF, 32'hAAAA_0002);
    chk("bp_ready_low", {31'h0, st_ready}, 32'h0);
    st_funct3 = 3'b010;
    st_addr   = 32'h0000_0508;
    st_data   = 32'hAAAA_0003;
    st_valid  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_stall_count", {30'h0, count}, 32'h2);
      chk("bp_stall_ready", {31'h0, st_ready}, 32'h0);
    end
    chk("bp_writing", {31'h0, mem_write}, 32'h1);
    man_resp = 1'b1;
    @(posedge clk);
    #1;
    man_resp = 1'b0;
    chk("bp_ready_back", {31'h0, st_ready}, 32'h1);
    chk("bp_count_pop", {30'h0, count}, 32'h1);
    sb.push_back('{a: 32'h0000_0508, be: 4'hF, d: 32'hAAAA_0003});
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    chk("bp_third_in", {30'h0, count}, 32'h2);
    resp_en = 1'b1;
    fixed_delay = 1;
    wait_drain();
    chk("bp_nwrites", nwrites, 7);

    // Wrap-around under random memory latency
    rnd_delay = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      issue(3'b010, 32'h0000_0600 + 32'(4 * i), 32'(i), 1'b0,
            32'h0000_0600 + 32'(4 * i), 4'hF, 32'(i));
    end
    wait_drain();
    chk("wrap_nwrites", nwrites, 14);
    chk("wrap_count", {30'h0, count}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
